// File: rtl/led_pwm_fader.sv
// led_pwm_fader: three-channel 8-bit PWM driver for the board RGB LED.
// Target colours arrive over a valid/ready handshake. Each channel then ramps
// linearly toward its target, so colour changes fade instead of stepping.
//
// Ports:
//   clk          system clock (24 MHz PLL output)
//   rst          asynchronous reset, active-high
//   in_valid     target colour valid
//   in_ready     a colour can be accepted (pending register empty)
//   in_r/g/b     8-bit target brightness per channel
//   led_r/g/b    registered PWM pin drive (inverted when ACTIVE_LOW=1)
//   period_start one-cycle pulse in the first cycle of each PWM period
//   busy         a target is pending or a fade is in progress
module led_pwm_fader #(
    parameter int unsigned CLK_DIV      = 24,
    parameter int unsigned FADE_PERIODS = 4,
    parameter bit          ACTIVE_LOW   = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_r,
    input  logic [7:0] in_g,
    input  logic [7:0] in_b,
    output logic       led_r,
    output logic       led_g,
    output logic       led_b,
    output logic       period_start,
    output logic       busy
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned FC_W  = (FADE_PERIODS > 1) ? $clog2(FADE_PERIODS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [FC_W-1:0]  FC_LAST  = FC_W'((FADE_PERIODS == 0) ? 0 : FADE_PERIODS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        FADE = 1'b1
    } state_t;

    // Channel vectors are ordered {r, g, b}: index 2 is red, 0 is blue.
    logic [DIV_W-1:0] div_cnt;
    logic [7:0]       pwm_cnt;
    state_t           state, state_n;
    logic [2:0][7:0]  pend, pend_n;
    logic [2:0][7:0]  ft, ft_n;
    logic [2:0][7:0]  cur, cur_n;
    logic [FC_W-1:0]  fade_cnt, fade_n;
    logic             in_ready_n;
    logic             busy_n;
    logic             tick;
    logic             bnd;
    logic             take;
    logic [2:0][7:0]  chan_in;

    assign chan_in = {in_r, in_g, in_b};
    assign tick    = (div_cnt == DIV_LAST);
    assign bnd     = tick && (pwm_cnt == 8'hFF);

    // Prescaler and free-running PWM count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            pwm_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
            pwm_cnt <= pwm_cnt + 8'd1;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Fade FSM next state; all brightness changes happen only at period boundaries
    always_comb begin
        state_n    = state;
        ft_n       = ft;
        cur_n      = cur;
        fade_n     = fade_cnt;
        take       = 1'b0;
        pend_n     = pend;
        in_ready_n = in_ready;

        if (bnd) begin
            case (state)
                IDLE: begin
                    if (!in_ready) begin
                        take    = 1'b1;
                        ft_n    = pend;
                        fade_n  = '0;
                        state_n = FADE;
                        if (FADE_PERIODS == 0) cur_n = pend;
                    end
                end
                FADE: begin
                    // Retarget: new colour replaces ft, ramp continues from cur
                    if (!in_ready) begin
                        take = 1'b1;
                        ft_n = pend;
                    end
                    if (FADE_PERIODS == 0) begin
                        if (!in_ready) cur_n = pend;
                        else           state_n = IDLE;
                    end else begin
                        if (fade_cnt == FC_LAST) begin
                            fade_n = '0;
                            for (int k = 0; k < 3; k++) begin
                                if (cur[k] < ft_n[k])      cur_n[k] = cur[k] + 8'd1;
                                else if (cur[k] > ft_n[k]) cur_n[k] = cur[k] - 8'd1;
                            end
                        end else begin
                            fade_n = fade_cnt + FC_W'(1);
                        end
                        if (cur_n == ft_n) state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end

        // Take and transfer are exclusive: a transfer needs the register empty
        if (take) begin
            in_ready_n = 1'b1;
        end else if (in_valid && in_ready) begin
            in_ready_n = 1'b0;
            pend_n     = chan_in;
        end

        busy_n = !in_ready_n || (state_n == FADE);
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            pend         <= '0;
            ft           <= '0;
            cur          <= '0;
            fade_cnt     <= '0;
            in_ready     <= 1'b1;
            busy         <= 1'b0;
            period_start <= 1'b0;
            led_r        <= ACTIVE_LOW;
            led_g        <= ACTIVE_LOW;
            led_b        <= ACTIVE_LOW;
        end else begin
            state        <= state_n;
            pend         <= pend_n;
            ft           <= ft_n;
            cur          <= cur_n;
            fade_cnt     <= fade_n;
            in_ready     <= in_ready_n;
            busy         <= busy_n;
            period_start <= bnd;
            led_r        <= (pwm_cnt < cur[2]) ^ ACTIVE_LOW;
            led_g        <= (pwm_cnt < cur[1]) ^ ACTIVE_LOW;
            led_b        <= (pwm_cnt < cur[0]) ^ ACTIVE_LOW;
        end
    end

endmodule

// File: tb/tb_led_pwm_fader.sv
// Testbench for led_pwm_fader: one instance with a 1-period ramp step, and one
// with instant updates and inverted pins, both checked every cycle against a
// reference model derived from edge counts and target/ramp rules.
module tb_led_pwm_fader;

    localparam int unsigned CLK_DIV = 2;
    localparam int unsigned PER     = CLK_DIV * 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic v1 = 1'b0, v0 = 1'b0;
    logic [7:0] r1 = '0, g1 = '0, b1 = '0, r0 = '0, g0 = '0, b0 = '0;
    logic u1_ready, u1_busy, u1_ps, u1_r, u1_g, u1_b;
    logic u0_ready, u0_busy, u0_ps, u0_r, u0_g, u0_b;
    logic [5:0] o1, o0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [23:0] q1[$];
    logic [23:0] q0[$];

    always #5 clk = ~clk;

    led_pwm_fader #(.CLK_DIV(CLK_DIV), .FADE_PERIODS(1), .ACTIVE_LOW(1'b0)) u1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(u1_ready),
        .in_r(r1), .in_g(g1), .in_b(b1),
        .led_r(u1_r), .led_g(u1_g), .led_b(u1_b),
        .period_start(u1_ps), .busy(u1_busy)
    );

    led_pwm_fader #(.CLK_DIV(CLK_DIV), .FADE_PERIODS(0), .ACTIVE_LOW(1'b1)) u0 (
        .clk(clk), .rst(rst), .in_valid(v0), .in_ready(u0_ready),
        .in_r(r0), .in_g(g0), .in_b(b0),
        .led_r(u0_r), .led_g(u0_g), .led_b(u0_b),
        .period_start(u0_ps), .busy(u0_busy)
    );

    assign o1 = {u1_ready, u1_busy, u1_ps, u1_r, u1_g, u1_b};
    assign o0 = {u0_ready, u0_busy, u0_ps, u0_r, u0_g, u0_b};

    // Reference model: e = clk edges since reset; pwm/boundary follow from it.
    typedef struct packed {
        int unsigned     e;
        logic            pending;
        logic [2:0][7:0] pend;
        logic [2:0][7:0] ft;
        logic [2:0][7:0] cur;
        logic            fading;
        int unsigned     fcnt;
        logic [5:0]      exp;   // {in_ready, busy, period_start, led_r, led_g, led_b}
    } mstate_t;

    function automatic mstate_t m_reset(logic al);
        mstate_t s = '0;
        s.exp = {1'b1, 1'b0, 1'b0, {3{al}}};
        return s;
    endfunction

    function automatic mstate_t m_step(mstate_t s, int unsigned fp, logic al,
                                       logic valid, logic [2:0][7:0] din);
        mstate_t     n   = s;
        int unsigned pwm = (s.e / CLK_DIV) % 256;
        logic        bnd = (((s.e + 1) % PER) == 0);
        logic [2:0]  led;
        for (int k = 0; k < 3; k++) led[k] = (pwm < int'(s.cur[k])) ^ al;
        n.e = s.e + 1;
        if (bnd) begin
            if (s.pending) begin
                n.ft      = s.pend;
                n.pending = 1'b0;
                if (fp == 0) n.cur = s.pend;
            end
            if (s.fading) begin
                if (fp == 0) begin
                    if (!s.pending) n.fading = 1'b0;
                end else begin
                    if (s.fcnt == fp - 1) begin
                        n.fcnt = 0;
                        for (int k = 0; k < 3; k++) begin
                            if (n.cur[k] < n.ft[k])      n.cur[k] = n.cur[k] + 8'd1;
                            else if (n.cur[k] > n.ft[k]) n.cur[k] = n.cur[k] - 8'd1;
                        end
                    end else begin
                        n.fcnt = s.fcnt + 1;
                    end
                    if (n.cur == n.ft) n.fading = 1'b0;
                end
            end else if (s.pending) begin
                n.fading = 1'b1;
                n.fcnt   = 0;
            end
        end
        if (valid && !s.pending) begin
            n.pending = 1'b1;
            n.pend    = din;
        end
        n.exp = {!n.pending, n.pending || n.fading, bnd, led};
        return n;
    endfunction

    mstate_t m1, m0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m1 <= m_reset(1'b0);
            m0 <= m_reset(1'b1);
        end else begin
            m1 <= m_step(m1, 1, 1'b0, v1, {r1, g1, b1});
            m0 <= m_step(m0, 0, 1'b1, v0, {r0, g0, b0});
        end
    end

    // Producer: present queue heads, hold until accepted, then advance one clk.
    task automatic step_both();
        logic acc1, acc0;
        if (q1.size() > 0) begin v1 = 1'b1; {r1, g1, b1} = q1[0]; end else v1 = 1'b0;
        if (q0.size() > 0) begin v0 = 1'b1; {r0, g0, b0} = q0[0]; end else v0 = 1'b0;
        acc1 = v1 && !m1.pending;
        acc0 = v0 && !m0.pending;
        @(posedge clk);
        #1;
        if (acc1) void'(q1.pop_front());
        if (acc0) void'(q0.pop_front());
        cyc++;
    endtask

    task automatic test_reset();
        int ps_cnt = 0;
        int first_ps = -1;
        #12;
        checks++;
        if (o1 !== 6'b100000) begin errors++; $display("FAIL reset_u1 got=%b want=%b", o1, 6'b100000); end
        checks++;
        if (o0 !== 6'b100111) begin errors++; $display("FAIL reset_u0 got=%b want=%b", o0, 6'b100111); end
        rst = 1'b0;
        for (int i = 1; i <= 2000; i++) begin
            step_both();
            checks++;
            if (o1 !== m1.exp) begin errors++; $display("FAIL idle_u1 cyc=%0d got=%b want=%b", cyc, o1, m1.exp); end
            checks++;
            if (o0 !== m0.exp) begin errors++; $display("FAIL idle_u0 cyc=%0d got=%b want=%b", cyc, o0, m0.exp); end
            if (u1_ps) begin ps_cnt++; if (first_ps < 0) first_ps = i; end
        end
        checks++;
        if (ps_cnt !== 3) begin errors++; $display("FAIL ps_count got=%0d want=3", ps_cnt); end
        checks++;
        if (first_ps !== int'(PER)) begin errors++; $display("FAIL ps_first got=%0d want=%0d", first_ps, PER); end
    endtask

    task automatic test_instant();
        int on_r = 0, on_g = 0, on_b = 0;
        q0.push_back({8'd128, 8'd0, 8'd255});
        for (int i = 0; i < 3 * int'(PER); i++) begin
            step_both();
            checks++;
            if (o0 !== m0.exp) begin errors++; $display("FAIL instant_u0 cyc=%0d got=%b want=%b", cyc, o0, m0.exp); end
        end
        for (int i = 0; i < int'(PER); i++) begin
            step_both();
            checks++;
            if (o0 !== m0.exp) begin errors++; $display("FAIL instant_u0 cyc=%0d got=%b want=%b", cyc, o0, m0.exp); end
            on_r += int'(!u0_r); on_g += int'(!u0_g); on_b += int'(!u0_b);
        end
        checks++;
        if (on_r !== 256 || on_g !== 0 || on_b !== 510) begin
            errors++;
            $display("FAIL instant_duty got=%0d/%0d/%0d want=256/0/510", on_r, on_g, on_b);
        end
        checks++;
        if (u0_busy !== 1'b0) begin errors++; $display("FAIL instant_busy got=%b want=0", u0_busy); end
    endtask

    task automatic test_ramp();
        int on_r = 0;
        q1.push_back({8'd4, 8'd0, 8'd0});
        for (int i = 0; i < 7 * int'(PER); i++) begin
            step_both();
            checks++;
            if (o1 !== m1.exp) begin errors++; $display("FAIL ramp_u1 cyc=%0d got=%b want=%b", cyc, o1, m1.exp); end
        end
        for (int i = 0; i < int'(PER); i++) begin
            step_both();
            checks++;
            if (o1 !== m1.exp) begin errors++; $display("FAIL ramp_u1 cyc=%0d got=%b want=%b", cyc, o1, m1.exp); end
            on_r += int'(u1_r);
        end
        checks++;
        if (on_r !== 8 || u1_busy !== 1'b0) begin
            errors++;
            $display("FAIL ramp_end got on=%0d busy=%b want on=8 busy=0", on_r, u1_busy);
        end
    endtask

    task automatic test_back_to_back();
        int stalled = 0;
        q1.push_back({8'd10, 8'd10, 8'd10});
        q1.push_back({8'd200, 8'd0, 8'd0});
        for (int i = 0; i < 5 * int'(PER); i++) begin
            step_both();
            checks++;
            if (o1 !== m1.exp) begin errors++; $display("FAIL b2b_u1 cyc=%0d got=%b want=%b", cyc, o1, m1.exp); end
            if (v1 && !u1_ready) stalled++;
        end
        checks++;
        if (stalled == 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL b2b_stall got stalled=%0d left=%0d want stalled>0 left=0", stalled, q1.size());
        end
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (o1 !== 6'b100000) begin errors++; $display("FAIL async_rst_u1 got=%b want=%b", o1, 6'b100000); end
        checks++;
        if (o0 !== 6'b100111) begin errors++; $display("FAIL async_rst_u0 got=%b want=%b", o0, 6'b100111); end
        q1.delete();
        q0.delete();
        v1 = 1'b0;
        v0 = 1'b0;
        #2;
        rst = 1'b0;
        for (int i = 0; i < 2 * int'(PER); i++) begin
            step_both();
            checks++;
            if (o1 !== m1.exp) begin errors++; $display("FAIL post_rst_u1 cyc=%0d got=%b want=%b", cyc, o1, m1.exp); end
            checks++;
            if (o0 !== m0.exp) begin errors++; $display("FAIL post_rst_u0 cyc=%0d got=%b want=%b", cyc, o0, m0.exp); end
        end
    endtask

    task automatic test_retarget();
        int on_r = 0;
        q1.push_back({8'd100, 8'd0, 8'd0});
        for (int i = 0; i < 60 * int'(PER); i++) begin
            step_both();
            checks++;
            if (o1 !== m1.exp) begin errors++; $display("FAIL retgt_up cyc=%0d got=%b want=%b", cyc, o1, m1.exp); end
            if (m1.cur[2] == 8'd50) break;
        end
        checks++;
        if (m1.cur[2] !== 8'd50) begin errors++; $display("FAIL retgt_reach50 got=%0d want=50", m1.cur[2]); end
        q1.push_back({8'd20, 8'd0, 8'd0});
        for (int i = 0; i < 40 * int'(PER); i++) begin
            step_both();
            checks++;
            if (o1 !== m1.exp) begin errors++; $display("FAIL retgt_down cyc=%0d got=%b want=%b", cyc, o1, m1.exp); end
            if (!m1.fading && !m1.pending && q1.size() == 0) break;
        end
        for (int i = 0; i < int'(PER); i++) begin
            step_both();
            checks++;
            if (o1 !== m1.exp) begin errors++; $display("FAIL retgt_hold cyc=%0d got=%b want=%b", cyc, o1, m1.exp); end
            on_r += int'(u1_r);
        end
        checks++;
        if (on_r !== 40 || u1_busy !== 1'b0) begin
            errors++;
            $display("FAIL retgt_end got on=%0d busy=%b want on=40 busy=0", on_r, u1_busy);
        end
    endtask

    task automatic test_random();
        logic [7:0] base;
        for (int j = 0; j < 3; j++) begin
            base = m1.cur[2];
            q1.push_back({8'(base + 8'($urandom_range(0, 6)) - 8'd3), 8'($urandom_range(0, 4)),
                          8'($urandom_range(0, 4))});
            q0.push_back(24'($urandom));
        end
        for (int i = 0; i < 12 * int'(PER); i++) begin
            if ($urandom_range(0, 3) == 0) begin
                v1 = 1'b0;
                @(posedge clk);
                #1;
                cyc++;
            end else begin
                step_both();
            end
            checks++;
            if (o1 !== m1.exp) begin errors++; $display("FAIL random_u1 cyc=%0d got=%b want=%b", cyc, o1, m1.exp); end
            checks++;
            if (o0 !== m0.exp) begin errors++; $display("FAIL random_u0 cyc=%0d got=%b want=%b", cyc, o0, m0.exp); end
        end
    endtask

    initial begin
        test_reset();
        test_instant();
        test_ramp();
        test_back_to_back();
        test_async_reset();
        test_retarget();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "simulation time limit expired");
    end

endmodule

// File: doc/led_pwm_fader.md
Name: led_pwm_fader

Overview:
- Drives the three board RGB LED pins with 8-bit PWM brightness per channel.
- Sits between the colour/pattern logic (clocked from the 24 MHz PLL output) and the top-level LED_R/LED_G/LED_B pins.
- Accepts new target colours over a valid/ready handshake and ramps each channel's brightness linearly toward its target, so colour changes fade instead of stepping.

Parameters:
- CLK_DIV, 24, clk cycles per PWM count; must be at least 1. At 24 MHz and 256 counts per period, the PWM rate is about 3.9 kHz.
- FADE_PERIODS, 4, PWM periods per 1-LSB brightness step. 0 means the new target is applied at the next period boundary with no ramp.
- ACTIVE_LOW, 0, when 1, the led_* outputs are inverted.

Ports:
- clk  in  1  system clock (24 MHz PLL output)
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  target colour valid
- in_ready  out  1  target register can accept a colour
- in_r  in  8  red target brightness
- in_g  in  8  green target brightness
- in_b  in  8  blue target brightness
- led_r  out  1  red PWM output
- led_g  out  1  green PWM output
- led_b  out  1  blue PWM output
- period_start  out  1  one-cycle pulse, high in the first cycle of each PWM period
- busy  out  1  a target is pending or a fade is in progress

Behaviour:
- Reset (asynchronous, active-high, all state):
  - div_cnt=0, pwm_cnt=0.
  - cur_r/g/b=0, fade target ft_r/g/b=0.
  - Pending target register empty, fade counter=0.
  - Outputs: in_ready=1, busy=0, period_start=0, led_*=0 (1 when ACTIVE_LOW=1).
  - Reset mid-fade discards all state and returns to these values.
- Prescaler:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - tick is asserted when div_cnt==CLK_DIV-1.
- PWM counter:
  - pwm_cnt (8 bit) increments on tick and wraps 255→0.
  - A period boundary is a tick with pwm_cnt==255.
  - period_start is registered: high for exactly the one clk cycle in which pwm_cnt first reads 0 after wrap. It stays 0 during the first period after reset.
- Outputs:
  - led_x is registered: led_x = (pwm_cnt < cur_x), XORed with ACTIVE_LOW.
  - One clk of latency from pwm_cnt/cur_x to pin.
  - cur_x=0 gives constant off; cur_x=255 gives on for 255 of every 256 counts; there is no 100% duty.
- Handshake:
  - in_ready = !pending.
  - A transfer occurs when in_valid && in_ready: in_r/g/b are captured into the pending register and pending is set.
  - When in_ready=0, in_valid is ignored and data is not captured.
  - The producer holds data until the transfer completes.
- FSM, states IDLE and FADE, evaluated only at period boundaries:
  - IDLE: if pending, copy the pending colour to ft_*, clear pending, reset the fade counter to 0, and go to FADE. in_ready returns to 1 the following cycle.
  - FADE with FADE_PERIODS==0: cur_*=ft_* at the same boundary the target is taken, then go to IDLE.
  - FADE otherwise: the fade counter increments each boundary. When it reaches FADE_PERIODS-1, it clears to 0 and each cur_x independently moves one LSB toward ft_x (+1 if below, -1 if above, hold if equal).
  - FADE exits to IDLE when all cur_x==ft_x.
  - A new pending target arriving during FADE is loaded into ft_* at the next boundary without leaving FADE. The fade counter is not reset, and the ramp continues from the current cur_* (retargeting).
  - Simultaneous boundary plus transfer: the transfer is only possible when pending=0, so it sets pending. The ft_ load happens at a later boundary.
- Update timing: cur_* changes only at period boundaries, so no partial-period glitches reach the pins.
- busy = pending || (state==FADE); it is registered.
- Arithmetic: cur_x stays within 0..255 with no wrap, because a step is taken only toward ft_x.

Test Plan (CLK_DIV=2, FADE_PERIODS=1, period = 512 clk):
- Reset → all led_*=0, in_ready=1, busy=0. Hold for 2000 clk: the LEDs stay 0, and period_start pulses every 512 clk starting at the second period.
- FADE_PERIODS=0; send r=128,g=0,b=255 → from the next boundary, led_r high 256 of 512 clk, led_g never high, led_b high 510 of 512 clk. busy drops one period after the load.
- Send r=4 from 0 → cur_r steps 1,2,3,4 on four consecutive boundaries, so led_r high 2, 4, 6, 8 clk per period. busy falls after cur_r==4.
- Back-pressure: send A=(10,10,10), then hold B=(200,0,0) valid immediately → in_ready=0 until the boundary consumes A. B is accepted next, and A is never overwritten.
- Retarget: mid-fade 0→100, at cur_r=50 send r=20 → cur_r decreases 49, 48, …, 20, then IDLE.
- Assert rst asynchronously mid-fade (not on a clk edge) → the outputs clear immediately. After release, the block behaves as from power-on.
